// File: rtl/banked_reg_file.sv
// -----------------------------------------------------------------------------
// banked_reg_file
//
// ARMv4 integer register file with per-mode banking of r8-r14, two write
// ports (A: ALU result, B: load data / base writeback) and an integrated PC
// sequencer on r15.
//
// Physical storage (31 entries, index = r_regs slot):
//   0-7    r0-r7, shared by all modes
//   8-12   r8-r12, usr copy (every mode except fiq)
//   13-14  r13-r14, usr/sys copy
//   15     r15 (PC)
//   16-20  r8-r12, fiq copy
//   21-22  r13-r14 fiq,  23-24 irq,  25-26 svc,  27-28 abt,  29-30 und
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mode[4:0]                current CPSR mode, decoded in the same cycle
//   usr_bank                 force usr mapping on every port (LDM/STM ^)
//   rn/rm/rs_addr[3:0]       combinational read addresses
//   rn/rm/rs_data            read data (r15 reads return pc + PC_READ_OFS)
//   wa_en/wa_addr/wa_data    write port A
//   wb_en/wb_addr/wb_data    write port B (wins on a same-register clash)
//   pc_inc                   advance r15 by PC_STEP when r15 is not written
//   pc                       raw r15
//   pc_written               r15 was loaded by a write port last cycle
//   wr_conflict              both ports hit one physical register last cycle
// -----------------------------------------------------------------------------
module banked_reg_file #(
  parameter int                DATA_W      = 32,
  parameter logic [DATA_W-1:0] SP_RESET    = 32'h0000_8000,
  parameter logic [DATA_W-1:0] PC_RESET    = 32'h0000_0000,
  parameter int                PC_STEP     = 4,
  parameter int                PC_READ_OFS = 8,
  parameter bit                BYPASS      = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        mode,
  input  logic              usr_bank,
  input  logic [3:0]        rn_addr,
  input  logic [3:0]        rm_addr,
  input  logic [3:0]        rs_addr,
  output logic [DATA_W-1:0] rn_data,
  output logic [DATA_W-1:0] rm_data,
  output logic [DATA_W-1:0] rs_data,
  input  logic              wa_en,
  input  logic [3:0]        wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wb_en,
  input  logic [3:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              pc_inc,
  output logic [DATA_W-1:0] pc,
  output logic              pc_written,
  output logic              wr_conflict
);

  localparam int NUM_PHYS = 31;

  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;

  // Slot of the r13 copy for each bank; r14 always sits in the next slot.
  localparam logic [4:0] R13_USR = 5'd13;
  localparam logic [4:0] R13_FIQ = 5'd21;
  localparam logic [4:0] R13_IRQ = 5'd23;
  localparam logic [4:0] R13_SVC = 5'd25;
  localparam logic [4:0] R13_ABT = 5'd27;
  localparam logic [4:0] R13_UND = 5'd29;
  localparam logic [4:0] PC_SLOT = 5'd15;

  // Architectural address + mode -> physical slot. usr, sys and any
  // unlisted encoding all resolve to the usr bank.
  function automatic logic [4:0] phys_idx(input logic [3:0] addr,
                                          input logic [4:0] mode_val,
                                          input logic       force_usr);
    logic [4:0] r13_base;
    logic       in_fiq;
    in_fiq = !force_usr && (mode_val == MODE_FIQ);
    case (mode_val)
      MODE_FIQ: r13_base = R13_FIQ;
      MODE_IRQ: r13_base = R13_IRQ;
      MODE_SVC: r13_base = R13_SVC;
      MODE_ABT: r13_base = R13_ABT;
      MODE_UND: r13_base = R13_UND;
      default:  r13_base = R13_USR;
    endcase
    if (force_usr) r13_base = R13_USR;
    phys_idx = {1'b0, addr};
    if (addr >= 4'd8 && addr <= 4'd12 && in_fiq)
      phys_idx = {1'b0, addr} + 5'd8;  // fiq r8-r12 live in slots 16-20
    else if (addr == 4'd13)
      phys_idx = r13_base;
    else if (addr == 4'd14)
      phys_idx = r13_base + 5'd1;
  endfunction

  function automatic logic [DATA_W-1:0] reset_value(input int idx);
    case (idx)
      13, 21, 23, 25, 27, 29: reset_value = SP_RESET;
      15:                     reset_value = PC_RESET;
      default:                reset_value = '0;
    endcase
  endfunction

  logic [DATA_W-1:0] r_regs [NUM_PHYS];
  logic              r_pc_written;
  logic              r_wr_conflict;

  logic [4:0]        w_pa;
  logic [4:0]        w_pb;
  logic              w_fwd_a;
  logic              w_fwd_b;
  logic              w_pc_wr;
  logic [3:0]        w_rd_addr [3];
  logic [4:0]        w_rd_phys [3];
  logic [DATA_W-1:0] w_rd_data [3];

  assign w_pa    = phys_idx(wa_addr, mode, usr_bank);
  assign w_pb    = phys_idx(wb_addr, mode, usr_bank);
  // A write in the reset cycle is discarded, so it is never forwarded either.
  assign w_fwd_a = BYPASS && wa_en && !rst;
  assign w_fwd_b = BYPASS && wb_en && !rst;
  assign w_pc_wr = (wa_en && wa_addr == 4'd15) || (wb_en && wb_addr == 4'd15);

  assign w_rd_addr[0] = rn_addr;
  assign w_rd_addr[1] = rm_addr;
  assign w_rd_addr[2] = rs_addr;

  // Read ports: stored value, overridden by A then B (B has priority), then
  // the pipeline offset for r15 applied on top of whichever value was chosen.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      // NOTE: every combinational output is given a value before any
      // conditional override, so no path leaves it unassigned (no latch).
      w_rd_phys[k] = phys_idx(w_rd_addr[k], mode, usr_bank);
      w_rd_data[k] = r_regs[w_rd_phys[k]];
      if (w_fwd_a && w_rd_phys[k] == w_pa) w_rd_data[k] = wa_data;
      if (w_fwd_b && w_rd_phys[k] == w_pb) w_rd_data[k] = wb_data;
      if (w_rd_addr[k] == 4'd15)
        w_rd_data[k] = w_rd_data[k] + DATA_W'(PC_READ_OFS);
    end
  end

  assign rn_data = w_rd_data[0];
  assign rm_data = w_rd_data[1];
  assign rs_data = w_rd_data[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage is plain flops, not a RAM macro, so every entry
      // gets a defined reset value and nothing downstream ever sees X.
      for (int i = 0; i < NUM_PHYS; i++) r_regs[i] <= reset_value(i);
      r_pc_written  <= 1'b0;
      r_wr_conflict <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments to the same slot resolve to the last
      // one executed, so the order below encodes the priority:
      // pc_inc < port A < port B.
      if (pc_inc) r_regs[PC_SLOT] <= r_regs[PC_SLOT] + DATA_W'(PC_STEP);
      if (wa_en)  r_regs[w_pa]    <= wa_data;
      if (wb_en)  r_regs[w_pb]    <= wb_data;
      r_pc_written  <= w_pc_wr;
      r_wr_conflict <= wa_en && wb_en && (w_pa == w_pb);
    end
  end

  assign pc          = r_regs[PC_SLOT];
  assign pc_written  = r_pc_written;
  assign wr_conflict = r_wr_conflict;

endmodule

// File: tb/tb_banked_reg_file.sv
// -----------------------------------------------------------------------------
// tb_banked_reg_file
//
// Drives two instances (BYPASS=1 and BYPASS=0) from the same inputs. Each
// cycle both are compared against a bank-level reference model held in an
// associative array keyed by (bank, architectural register). A directed
// table covers reset, banking, dual-write, bypass and PC behaviour; a couple
// of hand sequences and a randomized run follow.
// -----------------------------------------------------------------------------
module tb_banked_reg_file;

  localparam logic [4:0] U = 5'b10000;
  localparam logic [4:0] F = 5'b10001;
  localparam logic [4:0] I = 5'b10010;
  localparam logic [4:0] S = 5'b10011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  mode;
  logic        usr_bank;
  logic [3:0]  rn_addr, rm_addr, rs_addr;
  logic        wa_en, wb_en, pc_inc;
  logic [3:0]  wa_addr, wb_addr;
  logic [31:0] wa_data, wb_data;

  logic [31:0] b_rn, b_rm, b_rs, b_pc;
  logic        b_pw, b_wc;
  logic [31:0] n_rn, n_rm, n_rs, n_pc;
  logic        n_pw, n_wc;

  banked_reg_file #(.BYPASS(1'b1)) u_byp (
    .clk(clk), .rst(rst), .mode(mode), .usr_bank(usr_bank),
    .rn_addr(rn_addr), .rm_addr(rm_addr), .rs_addr(rs_addr),
    .rn_data(b_rn), .rm_data(b_rm), .rs_data(b_rs),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .pc_inc(pc_inc), .pc(b_pc), .pc_written(b_pw), .wr_conflict(b_wc)
  );

  banked_reg_file #(.BYPASS(1'b0)) u_nb (
    .clk(clk), .rst(rst), .mode(mode), .usr_bank(usr_bank),
    .rn_addr(rn_addr), .rm_addr(rm_addr), .rs_addr(rs_addr),
    .rn_data(n_rn), .rm_data(n_rm), .rs_data(n_rs),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .pc_inc(pc_inc), .pc(n_pc), .pc_written(n_pw), .wr_conflict(n_wc)
  );

  typedef struct {
    logic        rst;
    logic [4:0]  mode;
    logic        ub;
    logic        wa_en;
    logic [3:0]  wa_addr;
    logic [31:0] wa_data;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        pc_inc;
    logic [3:0]  rn, rm, rs;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [31:0] exp_rn, exp_rm, exp_rn_nb, exp_pc;
    logic        exp_pw, exp_wc;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mdl [int];
  logic        m_pw, m_wc;

  // Bank number: 0 usr/sys/other, 1 fiq, 2 irq, 3 svc, 4 abt, 5 und.
  function automatic int bank_of(input logic [4:0] m, input logic ub);
    if (ub) return 0;
    case (m)
      5'b10001: return 1;
      5'b10010: return 2;
      5'b10011: return 3;
      5'b10111: return 4;
      5'b11011: return 5;
      default:  return 0;
    endcase
  endfunction

  // Storage location key: r0-r7 and r15 are unbanked; r8-r12 split usr/fiq;
  // r13/r14 have one copy per bank.
  function automatic int key_of(input logic [3:0] a, input logic [4:0] m, input logic ub);
    int b;
    b = bank_of(m, ub);
    if (a < 4'd8 || a == 4'd15) return int'(a);
    if (a <= 4'd12) return (b == 1 ? 100 : 0) + int'(a);
    return b * 100 + int'(a);
  endfunction

  function automatic void mdl_reset();
    for (int a = 0; a < 16; a++) mdl[a] = 32'h0;
    for (int a = 8; a < 13; a++) mdl[100 + a] = 32'h0;
    for (int b = 0; b < 6; b++) begin
      mdl[b * 100 + 13] = 32'h0000_8000;
      mdl[b * 100 + 14] = 32'h0;
    end
    mdl[15] = 32'h0;
    m_pw = 1'b0;
    m_wc = 1'b0;
  endfunction

  function automatic logic [31:0] mdl_read(input stim_t s, input logic [3:0] a, input bit byp);
    int          k;
    logic [31:0] v;
    k = key_of(a, s.mode, s.ub);
    v = mdl[k];
    if (byp && !s.rst) begin
      if (s.wa_en && key_of(s.wa_addr, s.mode, s.ub) == k) v = s.wa_data;
      if (s.wb_en && key_of(s.wb_addr, s.mode, s.ub) == k) v = s.wb_data;
    end
    if (a == 4'd15) v = v + 32'd8;
    return v;
  endfunction

  function automatic void mdl_step(input stim_t s);
    int ka, kb;
    if (s.rst) begin
      mdl_reset();
      return;
    end
    ka = key_of(s.wa_addr, s.mode, s.ub);
    kb = key_of(s.wb_addr, s.mode, s.ub);
    m_pw = (s.wa_en && s.wa_addr == 4'd15) || (s.wb_en && s.wb_addr == 4'd15);
    m_wc = s.wa_en && s.wb_en && (ka == kb);
    if (s.pc_inc) mdl[15] = mdl[15] + 32'd4;
    if (s.wa_en) mdl[ka] = s.wa_data;
    if (s.wb_en) mdl[kb] = s.wb_data;
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic stim_t st(input logic r, input logic [4:0] m, input logic ub,
                               input logic ae, input logic [3:0] aa, input logic [31:0] ad,
                               input logic be, input logic [3:0] ba, input logic [31:0] bd,
                               input logic inc, input logic [3:0] rn, input logic [3:0] rm);
    stim_t s;
    s.rst = r; s.mode = m; s.ub = ub;
    s.wa_en = ae; s.wa_addr = aa; s.wa_data = ad;
    s.wb_en = be; s.wb_addr = ba; s.wb_data = bd;
    s.pc_inc = inc; s.rn = rn; s.rm = rm; s.rs = rm;
    return s;
  endfunction

  vec_t tbl[$];

  function automatic void add(input stim_t s, input logic [31:0] rn, input logic [31:0] rm,
                              input logic [31:0] rn_nb, input logic [31:0] p,
                              input logic pw, input logic wc);
    vec_t v;
    v.s = s; v.exp_rn = rn; v.exp_rm = rm; v.exp_rn_nb = rn_nb;
    v.exp_pc = p; v.exp_pw = pw; v.exp_wc = wc;
    tbl.push_back(v);
  endfunction

  // One clock: drive, check combinational reads, clock, check registered state.
  task automatic cycle(input stim_t s, input string tag,
                       output logic [31:0] c_rn, output logic [31:0] c_rm,
                       output logic [31:0] c_rn_nb, output logic [31:0] c_pc,
                       output logic c_pw, output logic c_wc);
    @(negedge clk);
    rst = s.rst; mode = s.mode; usr_bank = s.ub;
    wa_en = s.wa_en; wa_addr = s.wa_addr; wa_data = s.wa_data;
    wb_en = s.wb_en; wb_addr = s.wb_addr; wb_data = s.wb_data;
    pc_inc = s.pc_inc; rn_addr = s.rn; rm_addr = s.rm; rs_addr = s.rs;
    #1;
    c_rn = b_rn; c_rm = b_rm; c_rn_nb = n_rn;
    check({tag, " rn byp"}, b_rn, mdl_read(s, s.rn, 1'b1));
    check({tag, " rm byp"}, b_rm, mdl_read(s, s.rm, 1'b1));
    check({tag, " rs byp"}, b_rs, mdl_read(s, s.rs, 1'b1));
    check({tag, " rn nb"},  n_rn, mdl_read(s, s.rn, 1'b0));
    check({tag, " rm nb"},  n_rm, mdl_read(s, s.rm, 1'b0));
    check({tag, " rs nb"},  n_rs, mdl_read(s, s.rs, 1'b0));
    @(posedge clk);
    mdl_step(s);
    #1;
    c_pc = b_pc; c_pw = b_pw; c_wc = b_wc;
    check({tag, " pc byp"}, b_pc, mdl[15]);
    check({tag, " pc nb"},  n_pc, mdl[15]);
    check({tag, " pc_written byp"}, {31'b0, b_pw}, {31'b0, m_pw});
    check({tag, " pc_written nb"},  {31'b0, n_pw}, {31'b0, m_pw});
    check({tag, " wr_conflict byp"}, {31'b0, b_wc}, {31'b0, m_wc});
    check({tag, " wr_conflict nb"},  {31'b0, n_wc}, {31'b0, m_wc});
  endtask

  logic [31:0] c_rn, c_rm, c_rn_nb, c_pc;
  logic        c_pw, c_wc;
  logic [4:0]  mode_list [7] = '{5'b10000, 5'b10001, 5'b10010, 5'b10011,
                                 5'b10111, 5'b11011, 5'b11111};

  initial begin
    rst = 1'b1; mode = U; usr_bank = 1'b0;
    wa_en = 1'b0; wa_addr = '0; wa_data = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    pc_inc = 1'b0; rn_addr = '0; rm_addr = '0; rs_addr = '0;
    repeat (2) @(posedge clk);
    mdl_reset();

    // reset with a pending write
    add(st(1,U,0, 1,0,32'h5,      0,0,0, 0, 0,13), 32'h0,    32'h8000, 32'h0,    32'h0, 0, 0);
    add(st(0,U,0, 0,0,0,          0,0,0, 0, 0,15), 32'h0,    32'h8,    32'h0,    32'h0, 0, 0);
    // banking
    add(st(0,S,0, 1,13,32'h1000,  0,0,0, 0, 13,14), 32'h1000, 32'h0,   32'h8000, 32'h0, 0, 0);
    add(st(0,I,0, 1,13,32'h2000,  0,0,0, 0, 13,14), 32'h2000, 32'h0,   32'h8000, 32'h0, 0, 0);
    add(st(0,F,0, 1,8,32'hAA,     0,0,0, 0, 8,13),  32'hAA,   32'h8000, 32'h0,   32'h0, 0, 0);
    add(st(0,S,0, 0,0,0,          0,0,0, 0, 13,8),  32'h1000, 32'h0,   32'h1000, 32'h0, 0, 0);
    add(st(0,I,0, 0,0,0,          0,0,0, 0, 13,15), 32'h2000, 32'h8,   32'h2000, 32'h0, 0, 0);
    add(st(0,U,0, 0,0,0,          0,0,0, 0, 13,8),  32'h8000, 32'h0,   32'h8000, 32'h0, 0, 0);
    add(st(0,F,0, 0,0,0,          0,0,0, 0, 8,13),  32'hAA,   32'h8000, 32'hAA,  32'h0, 0, 0);
    add(st(0,F,1, 0,0,0,          0,0,0, 0, 8,13),  32'h0,    32'h8000, 32'h0,   32'h0, 0, 0);
    add(st(0,S,1, 0,0,0,          0,0,0, 0, 13,14), 32'h8000, 32'h0,   32'h8000, 32'h0, 0, 0);
    // dual write
    add(st(0,U,0, 1,3,32'h11,     1,4,32'h22, 0, 3,4), 32'h11, 32'h22, 32'h0,   32'h0, 0, 0);
    add(st(0,U,0, 1,5,32'h33,     1,5,32'h44, 0, 5,3), 32'h44, 32'h11, 32'h0,   32'h0, 0, 1);
    add(st(0,U,0, 0,0,0,          0,0,0, 0, 5,4),  32'h44,   32'h22,   32'h44,   32'h0, 0, 0);
    // bypass
    add(st(0,U,0, 1,2,32'h55,     0,0,0, 0, 2,2),  32'h55,   32'h55,   32'h0,    32'h0, 0, 0);
    add(st(0,U,0, 0,0,0,          0,0,0, 0, 2,2),  32'h55,   32'h55,   32'h55,   32'h0, 0, 0);
    // PC sequencing
    add(st(0,U,0, 0,0,0,          0,0,0, 1, 15,15), 32'h8,   32'h8,    32'h8,    32'h4, 0, 0);
    add(st(0,U,0, 0,0,0,          0,0,0, 1, 15,15), 32'hC,   32'hC,    32'hC,    32'h8, 0, 0);
    add(st(0,U,0, 0,0,0,          0,0,0, 1, 15,15), 32'h10,  32'h10,   32'h10,   32'hC, 0, 0);
    add(st(0,U,0, 0,0,0,          1,15,32'h100, 1, 15,15), 32'h108, 32'h108, 32'h14, 32'h100, 1, 0);
    add(st(0,U,0, 0,0,0,          0,0,0, 0, 15,0),  32'h108, 32'h0,    32'h108,  32'h100, 0, 0);
    add(st(0,U,0, 1,15,32'hFFFF_FFFC, 0,0,0, 0, 15,15), 32'h4, 32'h4,  32'h108,  32'hFFFF_FFFC, 1, 0);
    add(st(0,U,0, 0,0,0,          0,0,0, 1, 15,15), 32'h4,   32'h4,    32'h4,    32'h0, 0, 0);
    add(st(0,U,0, 1,15,32'h200,   0,0,0, 1, 15,15), 32'h208, 32'h208,  32'h8,    32'h200, 1, 0);
    add(st(0,U,0, 1,15,32'h300,   1,15,32'h400, 0, 15,15), 32'h408, 32'h408, 32'h208, 32'h400, 1, 1);
    // reset in the middle of banked activity
    add(st(0,S,0, 1,14,32'h77,    1,13,32'h1234, 0, 13,14), 32'h1234, 32'h77, 32'h1000, 32'h400, 0, 0);
    add(st(1,S,0, 0,0,0,          1,13,32'h9999, 0, 13,14), 32'h1234, 32'h77, 32'h1234, 32'h0, 0, 0);
    add(st(0,S,0, 0,0,0,          0,0,0, 0, 13,14), 32'h8000, 32'h0,   32'h8000, 32'h0, 0, 0);
    add(st(0,I,0, 0,0,0,          0,0,0, 0, 13,3),  32'h8000, 32'h0,   32'h8000, 32'h0, 0, 0);
    add(st(0,F,0, 0,0,0,          0,0,0, 0, 8,15),  32'h0,    32'h8,   32'h0,    32'h0, 0, 0);

    foreach (tbl[i]) begin
      string t;
      t = $sformatf("row%0d", i);
      cycle(tbl[i].s, t, c_rn, c_rm, c_rn_nb, c_pc, c_pw, c_wc);
      check({t, " tbl rn"},    c_rn,    tbl[i].exp_rn);
      check({t, " tbl rm"},    c_rm,    tbl[i].exp_rm);
      check({t, " tbl rn_nb"}, c_rn_nb, tbl[i].exp_rn_nb);
      check({t, " tbl pc"},    c_pc,    tbl[i].exp_pc);
      check({t, " tbl pw"},    {31'b0, c_pw}, {31'b0, tbl[i].exp_pw});
      check({t, " tbl wc"},    {31'b0, c_wc}, {31'b0, tbl[i].exp_wc});
    end

    // PC wrap across 2^32 under repeated pc_inc
    cycle(st(0,U,0, 0,0,0, 1,15,32'hFFFF_FFF0, 0, 15,15), "wrap load", c_rn, c_rm, c_rn_nb, c_pc, c_pw, c_wc);
    for (int k = 0; k < 5; k++)
      cycle(st(0,U,0, 0,0,0, 0,0,0, 1, 15,0), $sformatf("wrap inc%0d", k),
            c_rn, c_rm, c_rn_nb, c_pc, c_pw, c_wc);
    check("wrap final pc", c_pc, 32'h4);

    // reset held with pc_inc and a write: both discarded
    for (int k = 0; k < 2; k++)
      cycle(st(1,U,0, 1,1,32'hDEAD, 0,0,0, 1, 1,15), $sformatf("rst hold%0d", k),
            c_rn, c_rm, c_rn_nb, c_pc, c_pw, c_wc);
    check("rst hold pc", c_pc, 32'h0);
    cycle(st(0,U,0, 0,0,0, 0,0,0, 0, 1,15), "rst after", c_rn, c_rm, c_rn_nb, c_pc, c_pw, c_wc);
    check("rst after r1", c_rn, 32'h0);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      stim_t s;
      s.rst     = ($urandom_range(39) == 0);
      s.mode    = ($urandom_range(7) == 0) ? 5'($urandom) : mode_list[$urandom_range(6)];
      s.ub      = ($urandom_range(5) == 0);
      s.wa_en   = 1'($urandom);
      s.wa_addr = 4'($urandom);
      s.wa_data = $urandom;
      s.wb_en   = 1'($urandom);
      s.wb_addr = ($urandom_range(3) == 0) ? s.wa_addr : 4'($urandom);
      s.wb_data = $urandom;
      s.pc_inc  = 1'($urandom);
      s.rn      = ($urandom_range(2) == 0) ? s.wa_addr : 4'($urandom);
      s.rm      = ($urandom_range(2) == 0) ? s.wb_addr : 4'($urandom);
      s.rs      = 4'($urandom);
      cycle(s, $sformatf("rand%0d", n), c_rn, c_rm, c_rn_nb, c_pc, c_pw, c_wc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
